// File: rtl/seg7_pkg.sv
// Shared glyph definitions for the seven-segment scan driver.
// Segments a..g live at bits 0..6 and are active-high everywhere inside the design.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    localparam seg_t HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t seg7_glyph(input logic [3:0] nibble, input logic blank);
        return blank ? SEG_BLANK : HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder with a blank override.
// Output is active-high; polarity is handled by the caller.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_glyph(nibble, blank);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver with tear-free loading,
// leading-zero blanking, a guard cycle per slot and selectable output polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIV        = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic INACT = ACTIVE_LOW;

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend_val;
    logic [4*DIGITS-1:0] disp_val;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   disp_dp;

    logic                pre_wrap;
    logic                frame_end;
    logic [DIGITS-1:0]   lz;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [6:0]          glyph;
    logic [6:0]          seg_on;
    logic                dp_on;
    logic [DIGITS-1:0]   an_on;

    assign pre_wrap  = (pre == PRE_LAST);
    assign frame_end = enable && pre_wrap && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (enable) begin
            if (pre_wrap) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // A load landing on the commit edge goes straight to the display as well as pend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            if (frame_end) begin
                disp_val <= load ? value : pend_val;
                disp_dp  <= load ? dp : pend_dp;
            end
        end
    end

    // Digit i is blanked when it and every more significant nibble are zero.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (disp_val[4*i +: 4] == 4'h0);
            lz[i]    = blank_lz && zero_run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_val[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = lz[i];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (glyph)
    );

    always_comb begin
        seg_on = enable ? glyph : SEG_BLANK;
        dp_on  = enable && cur_dp && !cur_blank;
        an_on  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            an_on[i] = enable && (pre != '0) && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{INACT}};
            seg_dp     <= INACT;
            an         <= {DIGITS{INACT}};
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_on ^ {7{INACT}};
            seg_dp     <= dp_on ^ INACT;
            an         <= an_on ^ {DIGITS{INACT}};
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, DIV=4, with one active-low
// and one active-high instance sharing all stimulus.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz;

    logic [6:0]  seg_lo, seg_hi;
    logic        seg_dp_lo, seg_dp_hi;
    logic [3:0]  an_lo, an_hi;
    logic        fd_lo, fd_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp(dp), .blank_lz(blank_lz), .seg(seg_lo), .seg_dp(seg_dp_lo),
        .an(an_lo), .frame_done(fd_lo)
    );

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp(dp), .blank_lz(blank_lz), .seg(seg_hi), .seg_dp(seg_dp_hi),
        .an(an_hi), .frame_done(fd_hi)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advances until the active-low instance reports frame_done; bounded.
    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            tick();
            if (fd_lo === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset_initial;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
        repeat (3) tick();
        checks++;
        if (seg_lo !== 7'h7F || seg_dp_lo !== 1'b1 || an_lo !== 4'hF || fd_lo !== 1'b0) begin
            errors++;
            $display("FAIL reset_lo got seg=%h dp=%b an=%h fd=%b exp 7f 1 f 0", seg_lo, seg_dp_lo, an_lo, fd_lo);
        end
        checks++;
        if (seg_hi !== 7'h00 || seg_dp_hi !== 1'b0 || an_hi !== 4'h0 || fd_hi !== 1'b0) begin
            errors++;
            $display("FAIL reset_hi got seg=%h dp=%b an=%h fd=%b exp 00 0 0 0", seg_hi, seg_dp_hi, an_hi, fd_hi);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scan;
        bit ok;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        int slot, ph;
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        enable = 1'b1; value = 16'h1234; dp = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        sync_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_sync got no frame_done exp pulse"); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            slot = (k - 1) / 4; ph = (k - 1) % 4;
            exp_an = 4'b0001 << slot;
            if (ph == 0) exp_an = 4'h0;
            exp_an = ~exp_an;
            checks++;
            if (an_lo !== exp_an) begin
                errors++; $display("FAIL scan_an k=%0d got %h exp %h", k, an_lo, exp_an);
            end
            if (ph != 0) begin
                checks++;
                if (seg_lo !== exp_seg[slot] || seg_dp_lo !== 1'b1) begin
                    errors++; $display("FAIL scan_seg k=%0d got %h/%b exp %h/1", k, seg_lo, seg_dp_lo, exp_seg[slot]);
                end
            end
            checks++;
            if (fd_lo !== (k == 16)) begin
                errors++; $display("FAIL scan_fd k=%0d got %b exp %b", k, fd_lo, (k == 16));
            end
        end
    endtask

    task automatic test_tear_free;
        logic [6:0] exp_seg [4];
        logic       exp_dp [4];
        int slot, ph;
        // Frame 1: ABCD loaded at its start, old 1234 must remain; commit-edge load of 5678.
        value = 16'hABCD; dp = 4'h0; load = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f == 0) begin exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79}; exp_dp = '{1, 1, 1, 1}; end
            if (f == 1) begin exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08}; exp_dp = '{1, 1, 1, 1}; end
            if (f == 2) begin exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12}; exp_dp = '{0, 1, 1, 1}; end
            for (int k = 1; k <= 16; k++) begin
                tick();
                load = 1'b0;
                slot = (k - 1) / 4; ph = (k - 1) % 4;
                if (ph != 0) begin
                    checks++;
                    if (seg_lo !== exp_seg[slot] || seg_dp_lo !== exp_dp[slot]) begin
                        errors++;
                        $display("FAIL tear_seg f=%0d k=%0d got %h/%b exp %h/%b", f, k, seg_lo, seg_dp_lo, exp_seg[slot], exp_dp[slot]);
                    end
                end
                if (k == 16) begin
                    checks++;
                    if (fd_lo !== 1'b1) begin errors++; $display("FAIL tear_fd f=%0d got %b exp 1", f, fd_lo); end
                end
                if (f == 1 && k == 15) begin
                    value = 16'h5678; dp = 4'b0001; load = 1'b1;
                end
            end
        end
    endtask

    task automatic test_blank_lz;
        bit ok;
        logic [6:0] exp_seg [4];
        int slot, ph;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin value = 16'h0050; dp = 4'b0000; exp_seg = '{7'h40, 7'h12, 7'h7F, 7'h7F}; end
            else        begin value = 16'h0000; dp = 4'b1110; exp_seg = '{7'h40, 7'h7F, 7'h7F, 7'h7F}; end
            blank_lz = 1'b1; load = 1'b1;
            tick();
            load = 1'b0;
            sync_frame(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL lz_sync t=%0d got no frame_done exp pulse", t); end
            for (int k = 1; k <= 16; k++) begin
                tick();
                slot = (k - 1) / 4; ph = (k - 1) % 4;
                if (ph != 0) begin
                    checks++;
                    if (seg_lo !== exp_seg[slot] || seg_dp_lo !== 1'b1) begin
                        errors++;
                        $display("FAIL lz_seg t=%0d k=%0d got %h/%b exp %h/1", t, k, seg_lo, seg_dp_lo, exp_seg[slot]);
                    end
                end
            end
        end
    endtask

    task automatic test_enable;
        logic [3:0] exp_an [5];
        exp_an = '{4'hD, 4'hD, 4'hD, 4'hF, 4'hB};
        repeat (5) tick();
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (an_lo !== 4'hF || seg_lo !== 7'h7F || seg_dp_lo !== 1'b1 || fd_lo !== 1'b0) begin
                errors++;
                $display("FAIL en_off k=%0d got an=%h seg=%h dp=%b fd=%b exp f 7f 1 0", k, an_lo, seg_lo, seg_dp_lo, fd_lo);
            end
        end
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (an_lo !== exp_an[k]) begin
                errors++; $display("FAIL en_resume k=%0d got %h exp %h", k, an_lo, exp_an[k]);
            end
        end
    endtask

    task automatic test_polarity;
        bit ok;
        blank_lz = 1'b0;
        sync_frame(ok);
        value = 16'h0008; dp = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0;
        sync_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pol_sync got no frame_done exp pulse"); end
        tick();
        checks++;
        if (an_hi !== 4'h0) begin errors++; $display("FAIL pol_guard got an=%h exp 0", an_hi); end
        tick();
        checks++;
        if (seg_hi !== 7'h7F || seg_dp_hi !== 1'b1 || an_hi !== 4'h1) begin
            errors++;
            $display("FAIL pol_hi got seg=%h dp=%b an=%h exp 7f 1 1", seg_hi, seg_dp_hi, an_hi);
        end
    endtask

    task automatic test_reset_midscan;
        bit ok;
        int slot, ph;
        value = 16'hFFFF; dp = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (an_lo !== 4'hE) begin errors++; $display("FAIL mid_pre got an=%h exp e", an_lo); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg_lo !== 7'h7F || seg_dp_lo !== 1'b1 || an_lo !== 4'hF || fd_lo !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got seg=%h dp=%b an=%h fd=%b exp 7f 1 f 0", seg_lo, seg_dp_lo, an_lo, fd_lo);
        end
        tick();
        #2 rst_n = 1'b1;
        sync_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_sync got no frame_done exp pulse"); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            slot = (k - 1) / 4; ph = (k - 1) % 4;
            if (ph != 0) begin
                checks++;
                if (seg_lo !== 7'h40 || seg_dp_lo !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_lost k=%0d slot=%0d got %h/%b exp 40/1", k, slot, seg_lo, seg_dp_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset_initial();
        test_scan();
        test_tear_free();
        test_blank_lz();
        test_enable();
        test_polarity();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed multi-digit seven-segment display driver. It generalises the single-digit nibble-to-segment decoder to DIGITS digits sharing one segment bus, with a scan counter, tear-free value loading, leading-zero blanking, decimal points, an anti-ghosting guard cycle and selectable output polarity. It sits between the datapath (value source) and the board's segment/anode pins.

## Interface
- DIGITS, default 4: number of digits scanned, legal range 1..8.
- DIV, default 50000: clock cycles per digit slot, minimum 2.
- ACTIVE_LOW, default 1: when 1, both seg/seg_dp and an are active-low; when 0, active-high.
- clk  in  1  sole clock; all logic is on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- enable  in  1  scanning enable.
- load  in  1  single-cycle strobe that captures value/dp into the pending register.
- value  in  4*DIGITS  nibble i (bits 4i+3:4i) is the hex digit for digit i; digit 0 is the rightmost digit.
- dp  in  DIGITS  decimal point request per digit.
- blank_lz  in  1  enables leading-zero blanking.
- seg  out  7  segments a..g at bits 0..6.
- seg_dp  out  1  decimal-point segment.
- an  out  DIGITS  digit select, one-hot when active.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Counters:
  - pre counts 0..DIV-1.
  - On pre wrap, idx advances 0..DIGITS-1 and wraps to 0.
  - Both counters hold while enable=0.
- Registers:
  - pend_val/pend_dp are written on load.
  - disp_val/disp_dp drive the display.
  - Commit (pend → disp) happens only at frame end (pre==DIV-1, idx==DIGITS-1, enable=1), so there is no tearing.
  - load in the commit cycle: value/dp are committed directly, bypassing pend, and also written to pend.
- Glyphs:
  - Standard hex 0-F; a on for 0,2,3,5,6,7,8,9,A,C,E,F.
  - BLANK means all segments off, dp included.
- Leading-zero blanking: digit i (i>0) is BLANK when blank_lz=1 and disp nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Guard: during pre==0 of each slot, an is fully inactive, to prevent ghosting between digits.
- enable=0: an and seg/seg_dp are inactive; pending loads are still accepted.
- Polarity: logic is active-high internally; inversion is applied only at the output registers when ACTIVE_LOW=1.

## Timing
- Reset values (asynchronous, immediate):
  - pre=0, idx=0.
  - pend and disp zero.
  - seg, seg_dp and an all inactive (seg=7'h7F, an all ones, for ACTIVE_LOW=1).
  - frame_done=0.
- Outputs are registered: an/seg/seg_dp/frame_done reflect the (idx, pre, disp) of the previous cycle, one-cycle latency.
- Slot length: digit k is selected for exactly DIV-1 cycles per slot, preceded by 1 guard cycle.
- Frame length: DIGITS*DIV cycles. frame_done asserts once per frame, one cycle after the commit edge.
- New value latency: a load is displayed starting with the first slot of the frame after the next frame end.
- Re-enable resumes at the held idx/pre. There is no restart.
- rst_n asserted mid-frame: everything returns to reset values, and pending data is lost.
- DIGITS=1: idx is constant 0; the commit happens at every pre wrap.

## Structure
- Package seg7_pkg holds:
  - the SEG_BLANK constant;
  - the 16-entry hex glyph constant array (a..g, active-high);
  - the function mapping nibble+blank to segments.
- Sub-module seg7_hex_decoder: combinational nibble/blank → 7 active-high segments, instantiated once on the muxed digit.
- Top level contains the counters, the pend/disp registers, the blanking compare, the guard logic and the polarity output registers.

## Test plan
All scenarios use DIGITS=4, DIV=4, ACTIVE_LOW=1.
- Reset: hold rst_n=0 mid-scan → seg=7'h7F, seg_dp=1, an=4'hF, frame_done=0 immediately, with no clk edge needed.
- Scan order:
  - Stimulus: enable=1, load value=16'h1234, dp=0, wait one frame.
  - Each 4-cycle slot shows 1 cycle an=4'hF, then 3 cycles with an successively 4'hE, 4'hD, 4'hB, 4'h7.
  - seg matches 4, 3, 2, 1 respectively (digit "1" → seg=7'h79).
  - frame_done pulses every 16 cycles.
- Tear-free load:
  - Stimulus: load 16'hABCD mid-frame.
  - The current frame still shows the old value; the next frame shows D, C, B, A.
  - load in the commit cycle → the loaded value appears in the immediately following frame.
- Leading-zero blanking: blank_lz=1, value=16'h0050 → digits 3 and 2 show seg=7'h7F; digit 1 shows 5; digit 0 shows 0 (seg=7'h40).
- value=16'h0000 with blank_lz=1 → only digit 0 is lit, showing 0.
- Enable/polarity:
  - enable=0 for 10 cycles → outputs inactive; scan resumes at the held idx.
  - With ACTIVE_LOW=0 and digit 0 showing 8 (dp=1) → seg=7'h7F, seg_dp=1, an=4'h1.
